// File: rtl/macc_pipe_if.sv
// macc_pipe_if: sample-in / result-out handshake bundle for macc_pipe
interface macc_pipe_if #(
    parameter int unsigned A_W = 25,
    parameter int unsigned B_W = 18,
    parameter int unsigned P_W = 48
);
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           carryin;
    logic           acc_en;
    logic           clr;
    logic [P_W-1:0] p;
    logic           out_valid;
    logic           out_ready;
    logic           ovf;

    modport master (
        output in_valid, a, b, carryin, acc_en, clr, out_ready,
        input  in_ready, p, out_valid, ovf
    );

    modport slave (
        input  in_valid, a, b, carryin, acc_en, clr, out_ready,
        output in_ready, p, out_valid, ovf
    );
endinterface

// File: rtl/macc_pipe.sv
// macc_pipe: two-stage pipelined multiply-accumulate with valid/ready flow control
module macc_pipe #(
    parameter int unsigned A_W    = 25,
    parameter int unsigned B_W    = 18,
    parameter int unsigned P_W    = 48,
    parameter bit          SIGNED = 1'b0
) (
    input logic        clk,
    input logic        rst,
    macc_pipe_if.slave bus
);
    logic signed [A_W:0]       a_x;
    logic signed [B_W:0]       b_x;
    logic signed [A_W+B_W+1:0] prod;
    logic [P_W-1:0]            m_d;
    logic [P_W-1:0]            m_q;
    logic [P_W-1:0]            p_q;
    logic [P_W-1:0]            base;
    logic [P_W-1:0]            s1;
    logic [P_W:0]              sum;
    logic                      m_v;
    logic                      cin_q;
    logic                      acc_q;
    logic                      out_v;
    logic                      ovf_q;
    logic                      ov;
    logic                      s2_adv;
    logic                      in_rdy;

    // One extra operand bit lets a single signed multiplier serve both modes
    always_comb begin
        a_x  = {SIGNED & bus.a[A_W-1], bus.a};
        b_x  = {SIGNED & bus.b[B_W-1], bus.b};
        prod = a_x * b_x;
        m_d  = P_W'(prod);
    end

    // Stage-2 adder; s1 isolates the accumulate step for the signed overflow test
    always_comb begin
        base = acc_q ? p_q : '0;
        sum  = {1'b0, base} + {1'b0, m_q} + {{P_W{1'b0}}, cin_q};
        s1   = base + m_q;
        ov   = SIGNED ? ((acc_q & (base[P_W-1] == m_q[P_W-1]) & (s1[P_W-1] != base[P_W-1]))
                        | (cin_q & ~s1[P_W-1] & sum[P_W-1]))
                      : sum[P_W];
    end

    assign s2_adv        = m_v & (~out_v | bus.out_ready);
    assign in_rdy        = ~bus.clr & (~m_v | s2_adv);
    assign bus.in_ready  = in_rdy;
    assign bus.p         = p_q;
    assign bus.out_valid = out_v;
    assign bus.ovf       = ovf_q;

    // Stage 1: register the extended product with its carry-in and accumulate flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v   <= 1'b0;
            m_q   <= '0;
            cin_q <= 1'b0;
            acc_q <= 1'b0;
        end else if (bus.clr) begin
            m_v <= 1'b0;
        end else if (in_rdy) begin
            m_v <= bus.in_valid;
            if (bus.in_valid) begin
                m_q   <= m_d;
                cin_q <= bus.carryin;
                acc_q <= bus.acc_en;
            end
        end
    end

    // Stage 2: result/accumulator register, output valid and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q   <= '0;
            out_v <= 1'b0;
            ovf_q <= 1'b0;
        end else if (bus.clr) begin
            p_q   <= '0;
            out_v <= 1'b0;
            ovf_q <= 1'b0;
        end else if (s2_adv) begin
            p_q   <= sum[P_W-1:0];
            out_v <= 1'b1;
            ovf_q <= ovf_q | ov;
        end else if (bus.out_ready) begin
            out_v <= 1'b0;
        end
    end
endmodule

// File: tb/tb_macc_pipe.sv
// tb_macc_pipe: scoreboard bench for unsigned and signed macc_pipe instances
module tb_macc_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    macc_pipe_if bu ();
    macc_pipe_if bs ();

    macc_pipe #(.SIGNED(1'b0)) du (.clk(clk), .rst(rst), .bus(bu.slave));
    macc_pipe #(.SIGNED(1'b1)) ds (.clk(clk), .rst(rst), .bus(bs.slave));

    typedef struct {
        logic [47:0] p;
        logic        o;
    } exp_t;

    exp_t qu[$];
    exp_t qs[$];
    exp_t eu;
    exp_t es;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_u   = 0;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Unsigned instance monitor: every output transfer pops one expected result
    always @(negedge clk) begin
        if (rst && bu.out_valid && bu.out_ready) begin
            if (qu.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL u_unexpected: got p=%h, expected no output", bu.p);
            end else begin
                eu = qu.pop_front();
                chk("u_p", bu.p, eu.p);
                chk("u_ovf", {47'd0, bu.ovf}, {47'd0, eu.o});
            end
        end
    end

    // Signed instance monitor
    always @(negedge clk) begin
        if (rst && bs.out_valid && bs.out_ready) begin
            if (qs.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL s_unexpected: got p=%h, expected no output", bs.p);
            end else begin
                es = qs.pop_front();
                chk("s_p", bs.p, es.p);
                chk("s_ovf", {47'd0, bs.ovf}, {47'd0, es.o});
            end
        end
    end

    task automatic send_u(input int a, input int b, input logic cin, input logic acc,
                          input logic [47:0] ep, input logic eo, input bit push);
        bit rdy;
        int n = 0;
        #1;
        bu.in_valid = 1'b1;
        bu.a        = 25'(a);
        bu.b        = 18'(b);
        bu.carryin  = cin;
        bu.acc_en   = acc;
        do begin
            @(negedge clk);
            rdy = bu.in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_u_timeout: got in_ready=0, expected 1 within 200 cycles");
        end else begin
            acc_u++;
            if (push) qu.push_back('{ep, eo});
        end
    endtask

    task automatic send_s(input int a, input int b, input logic cin, input logic acc,
                          input logic [47:0] ep, input logic eo);
        bit rdy;
        int n = 0;
        #1;
        bs.in_valid = 1'b1;
        bs.a        = 25'(a);
        bs.b        = 18'(b);
        bs.carryin  = cin;
        bs.acc_en   = acc;
        do begin
            @(negedge clk);
            rdy = bs.in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_s_timeout: got in_ready=0, expected 1 within 200 cycles");
        end else begin
            qs.push_back('{ep, eo});
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((qu.size() != 0 || qs.size() != 0) && n < 1000);
        chk("drain_pending", 48'(qu.size() + qs.size()), 48'd0);
    endtask

    // 2^41 products accumulated up to 2^48-1, then +cin wraps to 0 and sets ovf
    task automatic ovf_run();
        send_u(1 << 24, 1 << 17, 1'b0, 1'b0, 48'h200_0000_0000, 1'b0, 1'b1);
        for (int k = 2; k <= 127; k++)
            send_u(1 << 24, 1 << 17, 1'b0, 1'b1, 48'(k) << 41, 1'b0, 1'b1);
        send_u(9560555, 230010, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
        send_u(0, 0, 1'b1, 1'b1, 48'd0, 1'b1, 1'b1);
        send_u(1, 1, 1'b0, 1'b1, 48'd1, 1'b1, 1'b1);
        #1 bu.in_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        {bu.in_valid, bu.a, bu.b, bu.carryin, bu.acc_en, bu.clr} = '0;
        {bs.in_valid, bs.a, bs.b, bs.carryin, bs.acc_en, bs.clr} = '0;
        bu.out_ready = 1'b1;
        bs.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p", bu.p, 48'd0);
        chk("rst_out_valid", {47'd0, bu.out_valid}, 48'd0);
        chk("rst_ovf", {47'd0, bu.ovf}, 48'd0);
        rst = 1'b1;
        @(posedge clk);

        send_u(3, 5, 1'b1, 1'b0, 48'd16, 1'b0, 1'b1);
        #1 bu.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid_cycle1", {47'd0, bu.out_valid}, 48'd0);
        @(negedge clk);
        chk("t1_valid_cycle2", {47'd0, bu.out_valid}, 48'd1);
        chk("t1_p", bu.p, 48'd16);
        drain();

        send_u(2, 3, 1'b0, 1'b0, 48'd6, 1'b0, 1'b1);
        send_u(4, 5, 1'b0, 1'b1, 48'd26, 1'b0, 1'b1);
        send_u(1, 1, 1'b0, 1'b1, 48'd27, 1'b0, 1'b1);
        #1 bu.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_p26", bu.p, 48'd26);
        @(negedge clk);
        chk("t2_p27", bu.p, 48'd27);
        drain();

        acc_u = 0;
        fork
            begin
                send_u(1, 1, 1'b0, 1'b0, 48'd1, 1'b0, 1'b1);
                send_u(2, 2, 1'b0, 1'b0, 48'd4, 1'b0, 1'b1);
                send_u(3, 3, 1'b0, 1'b0, 48'd9, 1'b0, 1'b1);
                send_u(4, 4, 1'b0, 1'b0, 48'd16, 1'b0, 1'b1);
                #1 bu.in_valid = 1'b0;
            end
            begin
                #1 bu.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("t3_accepts", 48'(acc_u), 48'd2);
                chk("t3_in_ready", {47'd0, bu.in_ready}, 48'd0);
                chk("t3_p_held", bu.p, 48'd1);
                chk("t3_out_valid", {47'd0, bu.out_valid}, 48'd1);
                @(posedge clk);
                #1 bu.out_ready = 1'b1;
            end
        join
        drain();

        ovf_run();
        #1;
        bu.clr      = 1'b1;
        bu.in_valid = 1'b1;
        bu.a        = 25'd7;
        bu.b        = 18'd7;
        bu.acc_en   = 1'b0;
        bu.carryin  = 1'b0;
        @(negedge clk);
        chk("clr_in_ready", {47'd0, bu.in_ready}, 48'd0);
        chk("ovf_sticky", {47'd0, bu.ovf}, 48'd1);
        @(posedge clk);
        #1;
        bu.clr      = 1'b0;
        bu.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", {47'd0, bu.out_valid}, 48'd0);
        chk("clr_ovf", {47'd0, bu.ovf}, 48'd0);
        chk("clr_p", bu.p, 48'd0);
        @(negedge clk);
        chk("clr_no_accept", {47'd0, bu.out_valid}, 48'd0);
        @(posedge clk);
        send_u(5, 5, 1'b0, 1'b1, 48'd25, 1'b0, 1'b1);
        #1 bu.in_valid = 1'b0;
        drain();

        ovf_run();
        #1 bu.out_ready = 1'b0;
        @(posedge clk);
        send_u(3, 3, 1'b0, 1'b1, 48'd0, 1'b0, 1'b0);
        send_u(3, 3, 1'b0, 1'b1, 48'd0, 1'b0, 1'b0);
        #3;
        chk("pre_rst_valid", {47'd0, bu.out_valid}, 48'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_p", bu.p, 48'd0);
        chk("arst_out_valid", {47'd0, bu.out_valid}, 48'd0);
        chk("arst_ovf", {47'd0, bu.ovf}, 48'd0);
        chk("arst_in_ready", {47'd0, bu.in_ready}, 48'd1);
        @(posedge clk);
        #1;
        bu.in_valid  = 1'b0;
        bu.out_ready = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        chk("post_rst_valid1", {47'd0, bu.out_valid}, 48'd0);
        @(negedge clk);
        chk("post_rst_valid2", {47'd0, bu.out_valid}, 48'd0);
        @(posedge clk);
        send_u(5, 5, 1'b0, 1'b1, 48'd25, 1'b0, 1'b1);
        #1 bu.in_valid = 1'b0;
        drain();

        send_s(-3, 7, 1'b0, 1'b0, 48'hFFFF_FFFF_FFEB, 1'b0);
        send_s(2, 2, 1'b0, 1'b1, 48'hFFFF_FFFF_FFEF, 1'b0);
        send_s(-1, -1, 1'b1, 1'b0, 48'd2, 1'b0);
        send_s(-4, 5, 1'b0, 1'b1, 48'hFFFF_FFFF_FFEE, 1'b0);
        #1 bs.in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
